sine_serial_rx: RTL and testbench

SINE_SERIAL_RX -- requirements
Module: sine_serial_rx

---
 rtl/sine_serial_rx_pkg.sv | 24 ++
 rtl/pwm_gen.sv | 41 ++++
 rtl/sine_serial_rx.sv | 114 +++++++++++
 tb/tb_sine_serial_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sine_serial_rx_pkg.sv
// Shared definitions for the serial sample receiver: FSM encoding, widths and a
// bit-placement helper used by the deserializer.
package sine_serial_rx_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_e;

   localparam int SAMPLE_W = 8;
   localparam int COUNT_W  = 16;
   localparam int BCNT_W   = 3;

   // Returns word with bit pos replaced by b.
   function automatic logic [SAMPLE_W-1:0] put_bit(input logic [SAMPLE_W-1:0] word,
                                                   input logic [BCNT_W-1:0]   pos,
                                                   input logic                b);
      logic [SAMPLE_W-1:0] res;
      res      = word;
      res[pos] = b;
      return res;
   endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM: counter advances on tick_enable, duty is latched only at the
// counter wrap so a period is never cut short, output is registered.
module pwm_gen #(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick_enable,
   input  logic [PWM_BITS-1:0] duty_in,
   output logic                pwm_out
);

   logic [PWM_BITS-1:0] pwm_cnt_r;
   logic [PWM_BITS-1:0] duty_r;
   logic                pwm_r;

   // Counter, period-aligned duty latch and comparator register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_r <= {PWM_BITS{1'b0}};
         duty_r    <= {PWM_BITS{1'b0}};
         pwm_r     <= 1'b0;
      end else begin
         if (tick_enable) begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
            if (pwm_cnt_r == {PWM_BITS{1'b1}}) begin
               duty_r <= duty_in;
            end else begin
               duty_r <= duty_r;
            end
         end else begin
            pwm_cnt_r <= pwm_cnt_r;
            duty_r    <= duty_r;
         end
         pwm_r <= (pwm_cnt_r < duty_r);
      end
   end

   assign pwm_out = pwm_r;

endmodule

// File: rtl/sine_serial_rx.sv
// MSB-first serial sample deserializer with frame abort detection, good-frame
// counter and PWM reconstruction of the last complete sample.
module sine_serial_rx
   import sine_serial_rx_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                SI,
   input  logic                SI_en,
   input  logic                soc,
   input  logic                tick_enable,
   output logic [SAMPLE_W-1:0] pdata,
   output logic                data_valid,
   output logic                frame_err,
   output logic [COUNT_W-1:0]  sample_count,
   output logic                pwm_out
);

   rx_state_e           state_r,  state_s;
   logic [BCNT_W-1:0]   bcnt_r,   bcnt_s;
   logic [SAMPLE_W-1:0] shift_r,  shift_s;
   logic [SAMPLE_W-1:0] pdata_r,  pdata_s;
   logic                valid_r,  valid_s;
   logic                err_r,    err_s;
   logic [COUNT_W-1:0]  count_r,  count_s;

   // Next-state and output decode for the deserializer.
   always_comb begin
      state_s = state_r;
      bcnt_s  = bcnt_r;
      shift_s = shift_r;
      pdata_s = pdata_r;
      valid_s = 1'b0;
      err_s   = 1'b0;
      count_s = count_r;
      case (state_r)
         IDLE: begin
            if (SI_en && soc) begin
               shift_s = put_bit({SAMPLE_W{1'b0}}, 3'd7, SI);
               bcnt_s  = 3'd1;
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (SI_en && soc) begin
               // Restart: the aborting bit becomes bit 7 of the new frame.
               err_s   = 1'b1;
               shift_s = put_bit({SAMPLE_W{1'b0}}, 3'd7, SI);
               bcnt_s  = 3'd1;
            end else if (SI_en) begin
               shift_s = put_bit(shift_r, 3'd7 - bcnt_r, SI);
               if (bcnt_r == 3'd7) begin
                  pdata_s = shift_s;
                  valid_s = 1'b1;
                  count_s = count_r + COUNT_W'(1);
                  shift_s = {SAMPLE_W{1'b0}};
                  bcnt_s  = 3'd0;
                  state_s = IDLE;
               end else begin
                  bcnt_s  = bcnt_r + 3'd1;
               end
            end else begin
               state_s = SHIFT;
            end
         end
         default: begin
            state_s = IDLE;
            bcnt_s  = 3'd0;
            shift_s = {SAMPLE_W{1'b0}};
         end
      endcase
   end

   // Deserializer state and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         bcnt_r  <= 3'd0;
         shift_r <= {SAMPLE_W{1'b0}};
         pdata_r <= {SAMPLE_W{1'b0}};
         valid_r <= 1'b0;
         err_r   <= 1'b0;
         count_r <= {COUNT_W{1'b0}};
      end else begin
         state_r <= state_s;
         bcnt_r  <= bcnt_s;
         shift_r <= shift_s;
         pdata_r <= pdata_s;
         valid_r <= valid_s;
         err_r   <= err_s;
         count_r <= count_s;
      end
   end

   assign pdata        = pdata_r;
   assign data_valid   = valid_r;
   assign frame_err    = err_r;
   assign sample_count = count_r;

   pwm_gen #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_enable (tick_enable),
      .duty_in     (pdata_r),
      .pwm_out     (pwm_out)
   );

endmodule

// File: tb/tb_sine_serial_rx.sv
// Self-checking bench for sine_serial_rx: frame table, scoreboard on data_valid,
// and hand-written abort, back-to-back, PWM and reset sequences.
module tb_sine_serial_rx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        si, si_en, soc, tick_enable;
   logic [7:0]  pdata;
   logic        data_valid, frame_err, pwm_out;
   logic [15:0] sample_count;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          err_cnt = 0;
   logic [23:0] exp_q[$];
   int          dv_cyc[$];
   logic [15:0] exp_count = 16'd0;
   logic [23:0] sb_e;

   typedef struct {
      logic [7:0] data;
      int         gap;      // stall cycles between bits; -1 = 0/1/5 pattern
      logic [7:0] exp_pdata;
   } frame_t;
   frame_t frames[5];

   sine_serial_rx #(.PWM_BITS(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .SI           (si),
      .SI_en        (si_en),
      .soc          (soc),
      .tick_enable  (tick_enable),
      .pdata        (pdata),
      .data_valid   (data_valid),
      .frame_err    (frame_err),
      .sample_count (sample_count),
      .pwm_out      (pwm_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every data_valid pops one expected {pdata, count}.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (frame_err === 1'b1) err_cnt++;
         if (data_valid === 1'b1) begin
            dv_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("dv_unexpected", 32'(data_valid), 32'(1'b0));
            end else begin
               sb_e = exp_q.pop_front();
               check("sb_pdata", 32'(pdata), 32'(sb_e[23:16]));
               check("sb_count", 32'(sample_count), 32'(sb_e[15:0]));
            end
         end
      end
   end

   task automatic drive(input logic en, input logic s, input logic b);
      si_en = en;
      soc   = s;
      si    = b;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int gap);
      int g;
      exp_count = exp_count + 16'd1;
      exp_q.push_back({d, exp_count});
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, (i == 0), d[7-i]);
         if (i < 7) begin
            g = (gap < 0) ? ((i % 3 == 0) ? 0 : ((i % 3 == 1) ? 1 : 5)) : gap;
            // soc and SI toggle during stalls and must be ignored
            for (int k = 0; k < g; k++) drive(1'b0, 1'b1, ~d[7-i]);
         end
      end
   endtask

   task automatic pwm_window(input string name, input int exp_high);
      int h;
      for (int k = 0; k < 520; k++) drive(1'b0, 1'b0, 1'b0);
      h = 0;
      for (int k = 0; k < 256; k++) begin
         drive(1'b0, 1'b0, 1'b0);
         if (pwm_out === 1'b1) h++;
      end
      check(name, 32'(h), 32'(exp_high));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] m;
      int         waited;
      frames[0] = '{8'hA5, 0,  8'hA5};
      frames[1] = '{8'h3C, 1,  8'h3C};
      frames[2] = '{8'h3C, 5,  8'h3C};
      frames[3] = '{8'h3C, -1, 8'h3C};
      frames[4] = '{8'h00, 2,  8'h00};

      rst_n = 1'b0; si = 1'b0; si_en = 1'b0; soc = 1'b0; tick_enable = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({pdata, data_valid, frame_err, sample_count, pwm_out}), 32'(0));
      rst_n = 1'b1;

      // Table-driven frames, first one starts on the first edge after release.
      for (int i = 0; i < 5; i++) begin
         send_frame(frames[i].data, frames[i].gap);
         check("tbl_valid", 32'(data_valid), 32'(1'b1));
         check("tbl_pdata", 32'(pdata), 32'(frames[i].exp_pdata));
         check("tbl_count", 32'(sample_count), 32'(exp_count));
         drive(1'b0, 1'b0, 1'b0);
         check("tbl_valid_pulse", 32'(data_valid), 32'(1'b0));
      end
      check("stall_no_err", 32'(err_cnt), 32'(0));

      // SI_en with soc=0 in IDLE is not a frame start.
      for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      check("idle_ignore", 32'(sample_count), 32'(exp_count));

      // Back-to-back frames, zero gap.
      dv_cyc.delete();
      send_frame(8'h01, 0);
      send_frame(8'hFE, 0);
      drive(1'b0, 1'b0, 1'b0);
      check("b2b_pulses", 32'(dv_cyc.size()), 32'(2));
      if (dv_cyc.size() == 2) check("b2b_spacing", 32'(dv_cyc[1] - dv_cyc[0]), 32'(8));
      check("b2b_pdata", 32'(pdata), 32'(8'hFE));

      // Abort after 4 bits of 0xFF, then a full 0x81 frame.
      for (int i = 0; i < 4; i++) drive(1'b1, (i == 0), 1'b1);
      exp_count = exp_count + 16'd1;
      exp_q.push_back({8'h81, exp_count});
      m = 8'h81;
      drive(1'b1, 1'b1, m[7]);
      check("abort_err", 32'(frame_err), 32'(1'b1));
      check("abort_pdata_held", 32'(pdata), 32'(8'hFE));
      for (int i = 1; i < 8; i++) begin
         drive(1'b1, 1'b0, m[7-i]);
         if (i == 1) check("abort_err_pulse", 32'(frame_err), 32'(1'b0));
      end
      check("abort_pdata", 32'(pdata), 32'(8'h81));
      check("abort_count", 32'(sample_count), 32'(exp_count));
      drive(1'b0, 1'b0, 1'b0);
      check("abort_err_total", 32'(err_cnt), 32'(1));

      // PWM duty 0x40 and 0xFF with tick_enable held high.
      send_frame(8'h40, 0);
      pwm_window("pwm_duty40", 64);
      send_frame(8'hFF, 0);
      pwm_window("pwm_duty255", 255);

      // Reset mid-frame after 5 bits, while pwm_out is high.
      m = 8'h5A;
      for (int i = 0; i < 5; i++) drive(1'b1, (i == 0), m[7-i]);
      waited = 0;
      while (pwm_out !== 1'b1 && waited < 300) begin
         drive(1'b0, 1'b0, 1'b0);
         waited++;
      end
      check("pwm_high_wait", 32'(pwm_out), 32'(1'b1));
      #2 rst_n = 1'b0;
      #1 check("async_reset", 32'({pdata, data_valid, frame_err, sample_count, pwm_out}), 32'(0));
      exp_q.delete();
      exp_count = 16'd0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(8'h5A, 0);
      check("rst_pdata", 32'(pdata), 32'(8'h5A));
      check("rst_count", 32'(sample_count), 32'(16'd1));
      drive(1'b0, 1'b0, 1'b0);
      check("rst_no_err", 32'(err_cnt), 32'(1));

      // Duty 0 keeps pwm_out low.
      send_frame(8'h00, 0);
      pwm_window("pwm_duty0", 0);
      check("queue_empty", 32'(exp_q.size()), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
